// File: rtl/m_csr_trap_unit_pkg.sv
// ============================================================================
// Module      : m_csr_trap_unit_pkg
// Description : CSR addresses, operation encodings, cause codes and shared
//               types for the machine-mode CSR file and trap controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package m_csr_trap_unit_pkg;

    localparam logic [11:0] c_CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] c_CSR_MIE       = 12'h304;
    localparam logic [11:0] c_CSR_MTVEC     = 12'h305;
    localparam logic [11:0] c_CSR_MSCRATCH  = 12'h340;
    localparam logic [11:0] c_CSR_MEPC      = 12'h341;
    localparam logic [11:0] c_CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] c_CSR_MTVAL     = 12'h343;
    localparam logic [11:0] c_CSR_MIP       = 12'h344;
    localparam logic [11:0] c_CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] c_CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] c_CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] c_CSR_MINSTRETH = 12'hB82;

    typedef enum logic [1:0] {
        c_OP_NONE = 2'b00,
        c_OP_RW   = 2'b01,
        c_OP_RS   = 2'b10,
        c_OP_RC   = 2'b11
    } csr_op_e;

    localparam int c_MSTATUS_MIE  = 3;
    localparam int c_MSTATUS_MPIE = 7;
    localparam int c_MEIE_BIT     = 11;
    localparam int c_MEIP_BIT     = 11;

    localparam logic [31:0] c_MSTATUS_RESET = 32'h0000_1800;
    localparam logic [3:0]  c_CAUSE_MEI     = 4'hB;

    // Resolved trap decision for the current cycle
    typedef struct packed {
        logic       take;
        logic       is_irq;
        logic [3:0] code;
    } trap_req_t;

endpackage

`default_nettype wire

// File: rtl/m_csr_trap_unit_if.sv
// ============================================================================
// Module      : m_csr_trap_unit_if
// Description : CSR access bus between the pipeline (master) and the CSR
//               file (slave).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface m_csr_trap_unit_if #(
    parameter int XLEN = 32
);
    logic [11:0]     i_csr_addr;
    logic [1:0]      i_csr_op;
    logic [XLEN-1:0] i_csr_wdata;
    logic [XLEN-1:0] o_csr_rdata;
    logic            o_csr_illegal;

    modport master (
        output i_csr_addr, i_csr_op, i_csr_wdata,
        input  o_csr_rdata, o_csr_illegal
    );

    modport slave (
        input  i_csr_addr, i_csr_op, i_csr_wdata,
        output o_csr_rdata, o_csr_illegal
    );
endinterface

`default_nettype wire

// File: rtl/m_csr_trap_unit_counter.sv
// ============================================================================
// Module      : m_csr_trap_unit_counter
// Description : Wide event counter with independent 32-bit lo/hi loads; a load
//               suppresses the increment in the same cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module m_csr_trap_unit_counter #(
    parameter int CNT_WIDTH = 64
) (
    input  wire logic        i_clk,
    input  wire logic        i_rst,
    input  wire logic        i_clk_en,
    input  wire logic        i_inc,
    input  wire logic        i_load_lo,
    input  wire logic        i_load_hi,
    input  wire logic [31:0] i_wdata,
    output logic      [31:0] o_lo,
    output logic      [31:0] o_hi
);
    localparam int c_HI_W = CNT_WIDTH - 32;

    logic [CNT_WIDTH-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_clk_en) begin
            if (i_load_lo || i_load_hi) begin
                if (i_load_lo) r_cnt[31:0]           <= i_wdata;
                if (i_load_hi) r_cnt[CNT_WIDTH-1:32] <= i_wdata[c_HI_W-1:0];
            end else if (i_inc) begin
                r_cnt <= r_cnt + CNT_WIDTH'(1);
            end
        end
    end

    assign o_lo = r_cnt[31:0];

    generate
        if (c_HI_W == 32) begin : g_hi_full
            assign o_hi = r_cnt[CNT_WIDTH-1:32];
        end else begin : g_hi_part
            logic w_unused_wdata;
            assign o_hi           = {{(32-c_HI_W){1'b0}}, r_cnt[CNT_WIDTH-1:32]};
            assign w_unused_wdata = ^i_wdata[31:c_HI_W];
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/m_csr_trap_unit.sv
// ============================================================================
// Module      : m_csr_trap_unit
// Description : Machine-mode CSR file and trap controller: CSR RMW, exception
//               and interrupt arbitration, mret, counters, redirect target.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module m_csr_trap_unit
    import m_csr_trap_unit_pkg::*;
#(
    parameter int              XLEN           = 32,
    parameter int              N_TRAP_SRC     = 2,
    parameter int              CNT_WIDTH      = 64,
    parameter logic [XLEN-1:0] MTVEC_RESET    = '0,
    parameter logic [XLEN-1:0] MSCRATCH_RESET = '0
) (
    input  wire logic                       i_clk,
    input  wire logic                       i_rst,
    input  wire logic                       i_clk_en,
    m_csr_trap_unit_if.slave                csr_bus,
    input  wire logic [N_TRAP_SRC-1:0]      i_trap_valid,
    input  wire logic [4*N_TRAP_SRC-1:0]    i_trap_code,
    input  wire logic [XLEN*N_TRAP_SRC-1:0] i_trap_pc,
    input  wire logic [XLEN*N_TRAP_SRC-1:0] i_trap_tval,
    input  wire logic                       i_irq_ext,
    input  wire logic [XLEN-1:0]            i_irq_pc,
    input  wire logic                       i_mret,
    input  wire logic                       i_instr_retire,
    output logic                            o_trap_taken,
    output logic      [XLEN-1:0]            o_redirect_pc,
    output logic                            o_mret_taken,
    output logic      [XLEN-1:0]            o_mepc,
    output logic      [XLEN-1:0]            o_mtvec,
    output logic      [XLEN-1:0]            o_mstatus
);
    localparam int              c_IDX_W      = (N_TRAP_SRC > 1) ? $clog2(N_TRAP_SRC) : 1;
    localparam logic [XLEN-1:0] c_ALIGN_MASK = {{(XLEN-2){1'b1}}, 2'b00};

    // Lowest asserted index wins
    function automatic logic [c_IDX_W-1:0] f_trap_prio(input logic [N_TRAP_SRC-1:0] v);
        f_trap_prio = '0;
        for (int k = N_TRAP_SRC - 1; k >= 0; k--) begin
            if (v[k]) f_trap_prio = c_IDX_W'(k);
        end
    endfunction

    function automatic logic [XLEN-1:0] f_csr_wval(input logic [1:0]      op,
                                                   input logic [XLEN-1:0] old,
                                                   input logic [XLEN-1:0] wdata);
        case (csr_op_e'(op))
            c_OP_RW: f_csr_wval = wdata;
            c_OP_RS: f_csr_wval = old | wdata;
            c_OP_RC: f_csr_wval = old & ~wdata;
            default: f_csr_wval = old;
        endcase
    endfunction

    logic            r_mie;
    logic            r_mpie;
    logic            r_meie;
    logic [XLEN-1:0] r_mtvec;
    logic [XLEN-1:0] r_mscratch;
    logic [XLEN-1:0] r_mepc;
    logic [XLEN-1:0] r_mcause;
    logic [XLEN-1:0] r_mtval;
    logic [XLEN-1:0] r_redirect_pc;
    logic            r_trap_taken;
    logic            r_mret_taken;

    logic [XLEN-1:0]    w_mstatus;
    logic [XLEN-1:0]    w_rdata;
    logic [XLEN-1:0]    w_wval;
    logic               w_supported;
    logic               w_read_only;
    logic               w_write_attempt;
    logic               w_illegal;
    logic               w_csr_we;
    logic               w_exc;
    logic               w_irq;
    logic               w_mret;
    logic [c_IDX_W-1:0] w_exc_idx;
    logic [3:0]         w_exc_code;
    logic [XLEN-1:0]    w_exc_pc;
    logic [XLEN-1:0]    w_exc_tval;
    trap_req_t          w_trap;
    logic [XLEN-1:0]    w_trap_pc;
    logic [XLEN-1:0]    w_trap_tval;
    logic [XLEN-1:0]    w_trap_mcause;
    logic [XLEN-1:0]    w_tvec_base;
    logic [XLEN-1:0]    w_trap_target;
    logic [31:0]        w_cyc_lo;
    logic [31:0]        w_cyc_hi;
    logic [31:0]        w_ins_lo;
    logic [31:0]        w_ins_hi;
    logic               w_cyc_ld_lo;
    logic               w_cyc_ld_hi;
    logic               w_ins_ld_lo;
    logic               w_ins_ld_hi;

    always_comb begin
        w_mstatus                 = XLEN'(c_MSTATUS_RESET);
        w_mstatus[c_MSTATUS_MIE]  = r_mie;
        w_mstatus[c_MSTATUS_MPIE] = r_mpie;
    end

    always_comb begin
        w_rdata     = '0;
        w_supported = 1'b1;
        w_read_only = 1'b0;
        case (csr_bus.i_csr_addr)
            c_CSR_MSTATUS:   w_rdata = w_mstatus;
            c_CSR_MIE:       w_rdata[c_MEIE_BIT] = r_meie;
            c_CSR_MTVEC:     w_rdata = r_mtvec;
            c_CSR_MSCRATCH:  w_rdata = r_mscratch;
            c_CSR_MEPC:      w_rdata = r_mepc;
            c_CSR_MCAUSE:    w_rdata = r_mcause;
            c_CSR_MTVAL:     w_rdata = r_mtval;
            c_CSR_MIP: begin
                w_rdata[c_MEIP_BIT] = i_irq_ext;
                w_read_only         = 1'b1;
            end
            c_CSR_MCYCLE:    w_rdata = XLEN'(w_cyc_lo);
            c_CSR_MCYCLEH:   w_rdata = XLEN'(w_cyc_hi);
            c_CSR_MINSTRET:  w_rdata = XLEN'(w_ins_lo);
            c_CSR_MINSTRETH: w_rdata = XLEN'(w_ins_hi);
            default:         w_supported = 1'b0;
        endcase
    end

    // RS/RC with a zero operand is a pure read, so it never counts as a write
    assign w_write_attempt = (csr_bus.i_csr_op == c_OP_RW) ||
                             ((csr_bus.i_csr_op != c_OP_NONE) && (|csr_bus.i_csr_wdata));
    assign w_illegal       = !w_supported || (w_read_only && w_write_attempt);
    assign w_wval          = f_csr_wval(csr_bus.i_csr_op, w_rdata, csr_bus.i_csr_wdata);

    assign csr_bus.o_csr_rdata   = w_rdata;
    assign csr_bus.o_csr_illegal = w_illegal;

    always_comb begin
        w_exc_idx  = f_trap_prio(i_trap_valid);
        w_exc      = |i_trap_valid;
        w_exc_code = i_trap_code[int'(w_exc_idx)*4 +: 4];
        w_exc_pc   = i_trap_pc[int'(w_exc_idx)*XLEN +: XLEN];
        w_exc_tval = i_trap_tval[int'(w_exc_idx)*XLEN +: XLEN];
    end

    assign w_irq  = !w_exc && r_mie && r_meie && i_irq_ext;
    assign w_mret = i_mret && !w_exc && !w_irq;

    always_comb begin
        w_trap.take   = w_exc || w_irq;
        w_trap.is_irq = !w_exc;
        w_trap.code   = w_exc ? w_exc_code : c_CAUSE_MEI;
        w_trap_pc     = (w_exc ? w_exc_pc : i_irq_pc) & c_ALIGN_MASK;
        w_trap_tval   = w_exc ? w_exc_tval : '0;
        w_trap_mcause = {w_trap.is_irq, {(XLEN-5){1'b0}}, w_trap.code};
        w_tvec_base   = r_mtvec & c_ALIGN_MASK;
        // Only interrupts are vectored; exceptions always land on the base
        if (w_trap.is_irq && r_mtvec[0])
            w_trap_target = w_tvec_base + XLEN'({w_trap.code, 2'b00});
        else
            w_trap_target = w_tvec_base;
    end

    assign w_csr_we    = w_write_attempt && !w_illegal && !w_trap.take && !w_mret;
    assign w_cyc_ld_lo = w_csr_we && (csr_bus.i_csr_addr == c_CSR_MCYCLE);
    assign w_cyc_ld_hi = w_csr_we && (csr_bus.i_csr_addr == c_CSR_MCYCLEH);
    assign w_ins_ld_lo = w_csr_we && (csr_bus.i_csr_addr == c_CSR_MINSTRET);
    assign w_ins_ld_hi = w_csr_we && (csr_bus.i_csr_addr == c_CSR_MINSTRETH);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_mie         <= 1'b0;
            r_mpie        <= 1'b0;
            r_meie        <= 1'b0;
            r_mtvec       <= MTVEC_RESET;
            r_mscratch    <= MSCRATCH_RESET & c_ALIGN_MASK;
            r_mepc        <= '0;
            r_mcause      <= '0;
            r_mtval       <= '0;
            r_redirect_pc <= '0;
            r_trap_taken  <= 1'b0;
            r_mret_taken  <= 1'b0;
        end else if (i_clk_en) begin
            r_trap_taken <= w_trap.take;
            r_mret_taken <= w_mret;
            if (w_trap.take) begin
                r_mepc        <= w_trap_pc;
                r_mcause      <= w_trap_mcause;
                r_mtval       <= w_trap_tval;
                r_mpie        <= r_mie;
                r_mie         <= 1'b0;
                r_redirect_pc <= w_trap_target;
            end else if (w_mret) begin
                r_mie         <= r_mpie;
                r_mpie        <= 1'b1;
                r_redirect_pc <= r_mepc;
            end else if (w_csr_we) begin
                case (csr_bus.i_csr_addr)
                    c_CSR_MSTATUS: begin
                        r_mie  <= w_wval[c_MSTATUS_MIE];
                        r_mpie <= w_wval[c_MSTATUS_MPIE];
                    end
                    c_CSR_MIE:      r_meie     <= w_wval[c_MEIE_BIT];
                    c_CSR_MTVEC:    r_mtvec    <= w_wval;
                    c_CSR_MSCRATCH: r_mscratch <= w_wval;
                    c_CSR_MEPC:     r_mepc     <= w_wval & c_ALIGN_MASK;
                    c_CSR_MCAUSE:   r_mcause   <= w_wval;
                    c_CSR_MTVAL:    r_mtval    <= w_wval;
                    default:        ;
                endcase
            end
        end
    end

    m_csr_trap_unit_counter #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_mcycle (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_clk_en  (i_clk_en),
        .i_inc     (1'b1),
        .i_load_lo (w_cyc_ld_lo),
        .i_load_hi (w_cyc_ld_hi),
        .i_wdata   (w_wval[31:0]),
        .o_lo      (w_cyc_lo),
        .o_hi      (w_cyc_hi)
    );

    m_csr_trap_unit_counter #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_minstret (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_clk_en  (i_clk_en),
        .i_inc     (i_instr_retire),
        .i_load_lo (w_ins_ld_lo),
        .i_load_hi (w_ins_ld_hi),
        .i_wdata   (w_wval[31:0]),
        .o_lo      (w_ins_lo),
        .o_hi      (w_ins_hi)
    );

    assign o_trap_taken  = r_trap_taken;
    assign o_mret_taken  = r_mret_taken;
    assign o_redirect_pc = r_redirect_pc;
    assign o_mepc        = r_mepc;
    assign o_mtvec       = r_mtvec;
    assign o_mstatus     = w_mstatus;

endmodule

`default_nettype wire

// File: tb/tb_m_csr_trap_unit.sv
// ============================================================================
// Module      : tb_m_csr_trap_unit
// Description : Directed and randomized self-checking bench for the CSR file
//               and trap controller, against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_m_csr_trap_unit;
    import m_csr_trap_unit_pkg::*;

    localparam int          c_CW      = 48;
    localparam logic [31:0] c_MTVEC_R = 32'h0000_0201;
    localparam logic [31:0] c_MSCR_R  = 32'hDEAD_BEEF;
    localparam longint unsigned c_CMASK = (64'd1 << c_CW) - 64'd1;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [1:0]  trap_valid;
    logic [7:0]  trap_code;
    logic [63:0] trap_pc;
    logic [63:0] trap_tval;
    logic        irq_ext;
    logic [31:0] irq_pc;
    logic        mret;
    logic        retire;
    logic        trap_taken;
    logic [31:0] redirect_pc;
    logic        mret_taken;
    logic [31:0] mepc;
    logic [31:0] mtvec;
    logic [31:0] mstatus;

    always #5 clk = ~clk;

    m_csr_trap_unit_if #(.XLEN(32)) bus ();

    m_csr_trap_unit #(
        .XLEN           (32),
        .N_TRAP_SRC     (2),
        .CNT_WIDTH      (c_CW),
        .MTVEC_RESET    (c_MTVEC_R),
        .MSCRATCH_RESET (c_MSCR_R)
    ) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_clk_en       (en),
        .csr_bus        (bus.slave),
        .i_trap_valid   (trap_valid),
        .i_trap_code    (trap_code),
        .i_trap_pc      (trap_pc),
        .i_trap_tval    (trap_tval),
        .i_irq_ext      (irq_ext),
        .i_irq_pc       (irq_pc),
        .i_mret         (mret),
        .i_instr_retire (retire),
        .o_trap_taken   (trap_taken),
        .o_redirect_pc  (redirect_pc),
        .o_mret_taken   (mret_taken),
        .o_mepc         (mepc),
        .o_mtvec        (mtvec),
        .o_mstatus      (mstatus)
    );

    int checks = 0;
    int errors = 0;

    // Architectural model state
    bit              m_mie, m_mpie, m_meie, m_trap, m_mret;
    bit [31:0]       m_mtvec, m_mscratch, m_mepc, m_mcause, m_mtval, m_redirect;
    longint unsigned m_cyc, m_ins;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit [31:0] m_status();
        return 32'h1800 | (32'(m_mie) << 3) | (32'(m_mpie) << 7);
    endfunction

    function automatic void mread(input logic [11:0] a, output bit sup, output bit ro,
                                  output bit [31:0] v);
        sup = 1'b1; ro = 1'b0; v = '0;
        case (a)
            12'h300: v = m_status();
            12'h304: v = 32'(m_meie) << 11;
            12'h305: v = m_mtvec;
            12'h340: v = m_mscratch;
            12'h341: v = m_mepc;
            12'h342: v = m_mcause;
            12'h343: v = m_mtval;
            12'h344: begin v = 32'(irq_ext) << 11; ro = 1'b1; end
            12'hB00: v = m_cyc[31:0];
            12'hB80: v = 32'(m_cyc >> 32);
            12'hB02: v = m_ins[31:0];
            12'hB82: v = 32'(m_ins >> 32);
            default: sup = 1'b0;
        endcase
    endfunction

    task automatic reset_model();
        m_mie = 0; m_mpie = 0; m_meie = 0; m_trap = 0; m_mret = 0;
        m_mtvec = c_MTVEC_R; m_mscratch = c_MSCR_R & ~32'd3;
        m_mepc = 0; m_mcause = 0; m_mtval = 0; m_redirect = 0;
        m_cyc = 0; m_ins = 0;
    endtask

    function automatic longint unsigned cnt_next(input longint unsigned c, input bit we,
                                                 input bit [11:0] a, input bit [11:0] a_lo,
                                                 input bit [31:0] wv, input bit inc);
        if (we && a == a_lo)              return (c & ~64'hFFFF_FFFF) | 64'(wv);
        if (we && a == (a_lo | 12'h080))  return ((c & 64'hFFFF_FFFF) | (64'(wv) << 32)) & c_CMASK;
        return (c + 64'(inc)) & c_CMASK;
    endfunction

    // One clock: check combinational read, advance the model, check outputs
    task automatic cycle();
        bit sup, ro, attempt, we, exc, irq, mr;
        bit [31:0] old, wv, base;
        bit [11:0] a;
        int idx;
        #1;
        a = bus.i_csr_addr;
        mread(a, sup, ro, old);
        attempt = (bus.i_csr_op == 2'b01) || (bus.i_csr_op != 2'b00 && bus.i_csr_wdata != 0);
        chk("rdata", bus.o_csr_rdata, old);
        chk("illegal", 32'(bus.o_csr_illegal), 32'(!sup || (ro && attempt)));
        case (bus.i_csr_op)
            2'b01:   wv = bus.i_csr_wdata;
            2'b10:   wv = old | bus.i_csr_wdata;
            2'b11:   wv = old & ~bus.i_csr_wdata;
            default: wv = old;
        endcase
        @(posedge clk);
        if (rst) begin
            reset_model();
        end else if (en) begin
            exc = |trap_valid;
            idx = trap_valid[0] ? 0 : 1;
            irq = !exc && m_mie && m_meie && irq_ext;
            mr  = mret && !exc && !irq;
            we  = attempt && sup && !ro && !exc && !irq && !mr;
            m_cyc = cnt_next(m_cyc, we, a, 12'hB00, wv, 1'b1);
            m_ins = cnt_next(m_ins, we, a, 12'hB02, wv, retire);
            m_trap = exc || irq;
            m_mret = mr;
            base = m_mtvec & ~32'd3;
            if (exc) begin
                m_mepc = trap_pc[idx*32 +: 32] & ~32'd3;
                m_mcause = {28'd0, trap_code[idx*4 +: 4]};
                m_mtval = trap_tval[idx*32 +: 32];
                m_mpie = m_mie; m_mie = 0;
                m_redirect = base;
            end else if (irq) begin
                m_mepc = irq_pc & ~32'd3;
                m_mcause = 32'h8000_000B;
                m_mtval = 0;
                m_mpie = m_mie; m_mie = 0;
                m_redirect = m_mtvec[0] ? base + 32'd44 : base;
            end else if (mr) begin
                m_mie = m_mpie; m_mpie = 1;
                m_redirect = m_mepc;
            end else if (we) begin
                case (a)
                    12'h300: begin m_mie = wv[3]; m_mpie = wv[7]; end
                    12'h304: m_meie = wv[11];
                    12'h305: m_mtvec = wv;
                    12'h340: m_mscratch = wv;
                    12'h341: m_mepc = wv & ~32'd3;
                    12'h342: m_mcause = wv;
                    12'h343: m_mtval = wv;
                    default: ;
                endcase
            end
        end
        #1;
        chk("trap_taken", 32'(trap_taken), 32'(m_trap));
        chk("mret_taken", 32'(mret_taken), 32'(m_mret));
        chk("redirect", redirect_pc, m_redirect);
        chk("mepc", mepc, m_mepc);
        chk("mtvec", mtvec, m_mtvec);
        chk("mstatus", mstatus, m_status());
    endtask

    task automatic csr(input logic [11:0] a, input logic [1:0] op, input logic [31:0] wd);
        bus.i_csr_addr = a; bus.i_csr_op = op; bus.i_csr_wdata = wd;
    endtask

    task automatic idle();
        csr(12'h000, 2'b00, 32'h0);
        trap_valid = 0; trap_code = 0; trap_pc = 0; trap_tval = 0;
        irq_ext = 0; irq_pc = 0; mret = 0; retire = 0;
    endtask

    task automatic peek(input string tag, input logic [11:0] a, input logic [31:0] exp_rd,
                        input logic exp_ill);
        csr(a, 2'b10, 32'h0);
        #1;
        chk({tag, "_rd"}, bus.o_csr_rdata, exp_rd);
        chk({tag, "_ill"}, 32'(bus.o_csr_illegal), 32'(exp_ill));
    endtask

    initial begin
        rst = 1'b1; en = 1'b1;
        idle();
        repeat (2) @(posedge clk);
        #1;
        reset_model();
        rst = 1'b0;
        chk("rst_mstatus", mstatus, 32'h1800);
        chk("rst_mtvec", mtvec, c_MTVEC_R);
        chk("rst_pulse", 32'(trap_taken), 32'd0);
        peek("rst_300", 12'h300, 32'h1800, 1'b0);
        peek("rst_305", 12'h305, c_MTVEC_R, 1'b0);
        peek("rst_340", 12'h340, 32'hDEAD_BEEC, 1'b0);
        peek("unk_7C0", 12'h7C0, 32'h0, 1'b1);
        cycle();

        // Exception arbitration: source 0 wins
        csr(12'h305, 2'b01, 32'h100); cycle();
        csr(12'h300, 2'b10, 32'h8);   cycle();
        idle();
        trap_valid = 2'b11; trap_code = {4'd5, 4'd2};
        trap_pc = {32'h80, 32'h40}; trap_tval = {32'h55, 32'h33};
        cycle();
        chk("exc_pulse", 32'(trap_taken), 32'd1);
        chk("exc_redirect", redirect_pc, 32'h100);
        chk("exc_mepc", mepc, 32'h40);
        chk("exc_mstatus", mstatus, 32'h1880);
        idle(); cycle();
        chk("exc_pulse_clr", 32'(trap_taken), 32'd0);
        peek("exc_mcause", 12'h342, 32'h2, 1'b0);

        // Vectored external interrupt
        csr(12'h305, 2'b01, 32'h101); cycle();
        csr(12'h300, 2'b10, 32'h8);   cycle();
        csr(12'h304, 2'b10, 32'h800); cycle();
        idle(); irq_ext = 1'b1; irq_pc = 32'h46;
        cycle();
        chk("irq_pulse", 32'(trap_taken), 32'd1);
        chk("irq_mepc", mepc, 32'h44);
        chk("irq_redirect", redirect_pc, 32'h12C);
        idle(); cycle();
        peek("irq_mcause", 12'h342, 32'h8000_000B, 1'b0);

        // Exception beats mret and a CSR write in the same cycle
        csr(12'h300, 2'b10, 32'h8); cycle();
        idle();
        trap_valid = 2'b10; trap_code = {4'd7, 4'd0}; trap_pc = {32'h88, 32'h0};
        mret = 1'b1; csr(12'h340, 2'b01, 32'h1234_5678);
        cycle();
        chk("prio_mret_dropped", 32'(mret_taken), 32'd0);
        idle(); cycle();
        peek("prio_mscratch", 12'h340, 32'hDEAD_BEEC, 1'b0);
        idle(); mret = 1'b1;
        cycle();
        chk("mret_pulse", 32'(mret_taken), 32'd1);
        chk("mret_redirect", redirect_pc, 32'h88);
        chk("mret_mstatus", mstatus, 32'h1888);

        // Counter carry across halves and clock-enable hold
        idle(); csr(12'hB00, 2'b01, 32'hFFFF_FFFF); cycle();
        csr(12'hB80, 2'b01, 32'h0); cycle();
        idle(); cycle();
        peek("cyc_hi", 12'hB80, 32'h1, 1'b0);
        peek("cyc_lo", 12'hB00, 32'h0, 1'b0);
        en = 1'b0;
        repeat (5) cycle();
        peek("cyc_hold", 12'hB00, 32'h0, 1'b0);
        en = 1'b1;

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            logic [11:0] addrs [13] = '{12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342,
                                        12'h343, 12'h344, 12'hB00, 12'hB80, 12'hB02, 12'hB82,
                                        12'h7C0};
            csr(addrs[$urandom_range(0, 12)], 2'($urandom),
                ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom);
            trap_valid = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            trap_code  = 8'($urandom);
            trap_pc    = {$urandom, $urandom};
            trap_tval  = {$urandom, $urandom};
            irq_ext    = ($urandom_range(0, 3) == 0);
            irq_pc     = $urandom;
            mret       = ($urandom_range(0, 9) == 0);
            retire     = 1'($urandom);
            en         = ($urandom_range(0, 7) != 0);
            cycle();
        end
        en = 1'b1;

        // Reset during a trap pulse
        idle(); trap_valid = 2'b01; trap_code = 8'h03; trap_pc = 64'h100;
        cycle();
        chk("rst_pre_pulse", 32'(trap_taken), 32'd1);
        idle(); rst = 1'b1;
        cycle();
        rst = 1'b0;
        chk("rst_pulse_clr", 32'(trap_taken), 32'd0);
        chk("rst2_mstatus", mstatus, 32'h1800);
        chk("rst2_mtvec", mtvec, c_MTVEC_R);
        chk("rst2_mepc", mepc, 32'h0);
        peek("rst2_340", 12'h340, 32'hDEAD_BEEC, 1'b0);
        peek("rst2_B00", 12'hB00, 32'h0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
